// File: rtl/trap_collector.sv
// Commit observer: counts RUN cycles/commits and reports the first nemu_trap (or watchdog timeout when TRAP_WATCHDOG_EN is defined).
// Latency: the trap strobe and its frozen payload appear 1 cycle after the trapping commit. Backpressure: none, the retire ports are observe-only.
module trap_collector #(
  parameter int COMMIT_WIDTH = 2,
  parameter int WDOG_LIMIT   = 5000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COMMIT_WIDTH-1:0]   commit_valid,
  input  logic [32*COMMIT_WIDTH-1:0] commit_pc,
  input  logic [32*COMMIT_WIDTH-1:0] commit_instr,
  input  logic [31:0]               trap_a0,
  output logic                      isNoopTrap,
  output logic [31:0]               trapCode,
  output logic [31:0]               trapPC,
  output logic [31:0]               cycleCnt,
  output logic [31:0]               instrCnt
);

  localparam logic [31:0] NEMU_TRAP = 32'h0000_006b;
  localparam logic [31:0] WDOG_CODE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_RUN, S_REPORT, S_HALT} state_e;

  state_e      state_q, state_d;
  logic        strobe_q, strobe_d;
  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic        trap_hit;
  logic [31:0] commit_cnt;
  logic [31:0] youngest_pc;
  logic        wdog_fire;
  logic [31:0] wdog_pc;

  // Scan stops at the oldest trapping lane; younger lanes are neither counted nor inspected.
  always_comb begin
    trap_hit    = 1'b0;
    commit_cnt  = '0;
    youngest_pc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!trap_hit && commit_valid[i]) begin
        commit_cnt  = commit_cnt + 32'd1;
        youngest_pc = commit_pc[32*i +: 32];
        if (commit_instr[32*i +: 32] == NEMU_TRAP) begin
          trap_hit = 1'b1;
        end
      end
    end
  end

`ifdef TRAP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic [31:0]   last_pc_q, last_pc_d;

  // Counter saturates at the limit so it cannot wrap while parked in HALT.
  always_comb begin
    wdog_d    = wdog_q;
    last_pc_d = last_pc_q;
    if (|commit_valid) begin
      wdog_d = '0;
    end else if (wdog_q != WW'(WDOG_LIMIT)) begin
      wdog_d = wdog_q + WW'(1);
    end
    if (state_q == S_RUN && (|commit_valid)) begin
      last_pc_d = youngest_pc;
    end
  end

  assign wdog_fire = (state_q == S_RUN) && (wdog_d == WW'(WDOG_LIMIT));
  assign wdog_pc   = last_pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog_q    <= '0;
      last_pc_q <= '0;
    end else begin
      wdog_q    <= wdog_d;
      last_pc_q <= last_pc_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_pc   = '0;
`endif

  always_comb begin
    state_d     = state_q;
    strobe_d    = 1'b0;
    code_d      = code_q;
    pc_d        = pc_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    case (state_q)
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q + commit_cnt;
        // A trap implies commits this cycle, so it outranks the watchdog.
        if (trap_hit) begin
          state_d  = S_REPORT;
          strobe_d = 1'b1;
          code_d   = trap_a0;
          pc_d     = youngest_pc;
        end else if (wdog_fire) begin
          state_d  = S_REPORT;
          strobe_d = 1'b1;
          code_d   = WDOG_CODE;
          pc_d     = wdog_pc;
        end
      end
      S_REPORT: state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      strobe_q    <= 1'b0;
      code_q      <= '0;
      pc_q        <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= strobe_d;
      code_q      <= code_d;
      pc_q        <= pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign isNoopTrap = strobe_q;
  assign trapCode   = code_q;
  assign trapPC     = pc_q;
  assign cycleCnt   = cycle_cnt_q;
  assign instrCnt   = instr_cnt_q;

endmodule

// File: tb/tb_trap_collector.sv
// Directed bench for trap_collector (COMMIT_WIDTH=2, WDOG_LIMIT=8) with a reference model feeding a scoreboard.
module tb_trap_collector;

  localparam logic [31:0] TRAP = 32'h0000_006b;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [1:0]  commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_instr;
  logic [31:0] trap_a0;
  logic        isNoopTrap;
  logic [31:0] trapCode, trapPC, cycleCnt, instrCnt;

  trap_collector #(.COMMIT_WIDTH(2), .WDOG_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .trap_a0(trap_a0),
    .isNoopTrap(isNoopTrap), .trapCode(trapCode), .trapPC(trapPC),
    .cycleCnt(cycleCnt), .instrCnt(instrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          checks   = 0;
  int          failures = 0;
  logic        m_run;
  logic [31:0] m_cyc, m_ins, m_lastpc;
  int          m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (isNoopTrap !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", {31'd0, isNoopTrap}, 32'd0);
      end else begin
        e        = sb.pop_front();
        last_exp = e;
        chk("trapCode", trapCode, e.code);
        chk("trapPC",   trapPC,   e.pc);
        chk("cycleCnt", cycleCnt, e.cyc);
        chk("instrCnt", instrCnt, e.ins);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b0;
    commit_valid = '0;
    commit_pc    = '0;
    commit_instr = '0;
    trap_a0      = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_strobe",   {31'd0, isNoopTrap}, 32'd0);
    chk("rst_trapCode", trapCode, 32'd0);
    chk("rst_trapPC",   trapPC,   32'd0);
    chk("rst_cycleCnt", cycleCnt, 32'd0);
    chk("rst_instrCnt", instrCnt, 32'd0);
    reset    = 1'b1;
    m_run    = 1'b1;
    m_cyc    = '0;
    m_ins    = '0;
    m_idle   = 0;
    m_lastpc = '0;
    sb.delete();
  endtask

  // Drive one cycle, update the reference model, then advance and check.
  task automatic run_cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] a);
    logic [31:0] ins[2];
    logic [31:0] pcs[2];
    logic        trapped;
    logic        pushed;
    logic [31:0] tpc;
    ins[0] = i0; ins[1] = i1; pcs[0] = p0; pcs[1] = p1;
    commit_valid = v;
    commit_instr = {i1, i0};
    commit_pc    = {p1, p0};
    trap_a0      = a;
    trapped      = 1'b0;
    pushed       = 1'b0;
    tpc          = '0;
    if (m_run) begin
      m_cyc = m_cyc + 32'd1;
      for (int l = 0; l < 2; l++) begin
        if (!trapped && v[l]) begin
          m_ins = m_ins + 32'd1;
          tpc   = pcs[l];
          if (ins[l] == TRAP) trapped = 1'b1;
        end
      end
      if (v != 2'b00) begin
        m_idle   = 0;
        m_lastpc = tpc;
      end else begin
        m_idle++;
      end
      if (trapped) begin
        sb.push_back('{code: a, pc: tpc, cyc: m_cyc, ins: m_ins});
        pushed = 1'b1;
        m_run  = 1'b0;
      end
`ifdef TRAP_WATCHDOG_EN
      else if (m_idle == 8) begin
        sb.push_back('{code: 32'hFFFF_FFFF, pc: m_lastpc, cyc: m_cyc, ins: m_ins});
        pushed = 1'b1;
        m_run  = 1'b0;
      end
`endif
    end
    step();
    if (pushed) chk("strobe_latency", sb.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset        = 1'b0;
    commit_valid = '0;
    commit_pc    = '0;
    commit_instr = '0;
    trap_a0      = '0;

    // Basic trap: 10 dual commits, then lane0 traps (lane1 younger, ignored).
    do_reset(3);
    for (int c = 0; c < 10; c++)
      run_cycle(2'b11, NOP, NOP, 32'h8000_0000 + 8*c, 32'h8000_0004 + 8*c, 32'h0);
    run_cycle(2'b11, TRAP, NOP, 32'h8000_0100, 32'h8000_0104, 32'h0);
    chk("basic_cyc", last_exp.cyc, 32'd11);
    chk("basic_ins", last_exp.ins, 32'd21);

    // Post-trap inertness.
    for (int c = 0; c < 20; c++) begin
      run_cycle(2'b11, TRAP, TRAP, 32'h9000_0000 + c, 32'h9000_1000 + c, 32'h55);
      chk("halt_strobe",   {31'd0, isNoopTrap}, 32'd0);
      chk("halt_trapCode", trapCode, last_exp.code);
      chk("halt_trapPC",   trapPC,   last_exp.pc);
      chk("halt_cycleCnt", cycleCnt, last_exp.cyc);
      chk("halt_instrCnt", instrCnt, last_exp.ins);
    end

    // Lane priority: only lane1 traps, then both trap.
    do_reset(2);
    run_cycle(2'b11, NOP, TRAP, 32'h8000_0200, 32'h8000_0204, 32'h1);
    chk("lane1_ins", last_exp.ins, 32'd2);
    do_reset(2);
    run_cycle(2'b11, TRAP, TRAP, 32'h8000_0300, 32'h8000_0304, 32'h5);
    chk("both_pc",  last_exp.pc,  32'h8000_0300);
    chk("both_ins", last_exp.ins, 32'd1);

    // Non-contiguous masks, trap in lane1 with lane0 idle.
    do_reset(2);
    run_cycle(2'b10, NOP, NOP, 32'h8000_0400, 32'h8000_0404, 32'h0);
    run_cycle(2'b01, NOP, NOP, 32'h8000_0408, 32'h8000_040c, 32'h0);
    run_cycle(2'b11, NOP, NOP, 32'h8000_0410, 32'h8000_0414, 32'h0);
    run_cycle(2'b10, TRAP, TRAP, 32'h8000_0418, 32'h8000_041c, 32'h7);
    chk("nc_ins", last_exp.ins, 32'd5);

    // Reset asserted in the strobe cycle, then a fresh trap counts from zero.
    do_reset(2);
    for (int c = 0; c < 3; c++)
      run_cycle(2'b11, NOP, NOP, 32'h8000_0500 + 8*c, 32'h8000_0504 + 8*c, 32'h0);
    run_cycle(2'b01, TRAP, NOP, 32'h8000_0520, 32'h0, 32'h9);
    do_reset(1);
    run_cycle(2'b11, NOP, NOP, 32'h8000_0600, 32'h8000_0604, 32'h0);
    run_cycle(2'b01, TRAP, NOP, 32'h8000_0608, 32'h0, 32'h3);
    chk("rerun_cyc", last_exp.cyc, 32'd2);
    chk("rerun_ins", last_exp.ins, 32'd3);

    // instrCnt wrap via preload during an idle cycle.
    do_reset(2);
    run_cycle(2'b11, NOP, NOP, 32'h8000_0700, 32'h8000_0704, 32'h0);
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    m_ins = 32'hFFFF_FFFF;
    run_cycle(2'b00, NOP, NOP, 32'h0, 32'h0, 32'h0);
    release dut.instr_cnt_q;
    chk("prewrap_ins", instrCnt, m_ins);
    run_cycle(2'b11, NOP, NOP, 32'h8000_0708, 32'h8000_070c, 32'h0);
    chk("wrap_ins", instrCnt, 32'd1);
    run_cycle(2'b01, TRAP, NOP, 32'h8000_0710, 32'h0, 32'h0);

`ifdef TRAP_WATCHDOG_EN
    // Watchdog: one commit then idle; strobe expected 9 cycles after the commit.
    do_reset(2);
    run_cycle(2'b01, NOP, NOP, 32'h8000_0010, 32'h0, 32'h0);
    for (int c = 0; c < 12; c++)
      run_cycle(2'b00, NOP, NOP, 32'h0, 32'h0, 32'h0);
    chk("wdog_code", last_exp.code, 32'hFFFF_FFFF);
    chk("wdog_cyc",  last_exp.cyc,  32'd9);
`else
    // No watchdog: a long idle stretch must never strobe.
    do_reset(2);
    for (int c = 0; c < 10000; c++)
      run_cycle(2'b00, NOP, NOP, 32'h0, 32'h0, 32'h0);
    chk("idle_strobe",   {31'd0, isNoopTrap}, 32'd0);
    chk("idle_cycleCnt", cycleCnt, 32'd10000);
    chk("idle_instrCnt", instrCnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_collector.md
# trap_collector

Simulation-side commit observer that sits directly upstream of the trap monitor. It watches the retire ports of the core and counts cycles and committed instructions. On the first committed `nemu_trap` instruction (`32'h0000006b`) it latches the trap code and PC, then raises a one-cycle trap strobe carrying frozen counter values. The strobe and payload wire straight into the monitor's `isNoopTrap`/`trapCode`/`trapPC`/`cycleCnt`/`instrCnt` inputs.

## Interface
- `COMMIT_WIDTH`, 2, number of retire lanes per cycle (1..8)
- `WDOG_LIMIT`, 5000, consecutive no-commit cycles that trigger a timeout trap (used only with watchdog compiled in)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low: state is cleared on any rising edge of `clk` where `reset`==0
- `commit_valid`  in  COMMIT_WIDTH  per-lane retire valid; lane 0 is oldest
- `commit_pc`  in  32*COMMIT_WIDTH  lane i PC at bits [32i+31:32i]
- `commit_instr`  in  32*COMMIT_WIDTH  lane i instruction word, same packing
- `trap_a0`  in  32  architectural a0 value as seen by the oldest trapping lane in the current cycle
- `isNoopTrap`  out  1  one-cycle trap strobe
- `trapCode`  out  32  trap code (a0 value, or timeout code)
- `trapPC`  out  32  PC of the trapping instruction
- `cycleCnt`  out  32  cycles spent in RUN, including the trap cycle
- `instrCnt`  out  32  instructions committed, including the trap instruction

## Operation
- States: RUN, REPORT, HALT. Reset enters RUN.
- Reset (`reset`==0): state=RUN. All five outputs = 0. Watchdog counter = 0. Last-commit PC = 0.
- Trap detect (RUN only): lane i traps when `commit_valid[i]` && `commit_instr[i]`==`32'h0000006b`. The lowest-index trapping lane t wins.
- RUN, each cycle:
  - `cycleCnt` += 1.
  - `instrCnt` += popcount of valid lanes with index ≤ t, or of all valid lanes if there is no trap.
  - Lanes younger than t are neither counted nor inspected.
  - Both counters wrap modulo 2^32.
- RUN with trap: latch `trapCode`=`trap_a0` and `trapPC`=`commit_pc[t]`, then go to REPORT.
- REPORT: `isNoopTrap`=1 for exactly this cycle. Counters frozen. Commit inputs ignored. Go to HALT.
- HALT: `isNoopTrap`=0. All payload outputs hold. Commit inputs ignored. Leave only on reset.
- Non-contiguous valid masks are legal: each set bit is counted independently.

## Timing
- All outputs are registered.
- Trap committed in RUN cycle k (k=1 is the first cycle after reset is released): `isNoopTrap` is high in cycle k+1 with `cycleCnt`=k, and the payload is stable from cycle k+1 onward.
- Latency from trap commit to strobe: 1 cycle.
- `trapCode`/`trapPC` change only on the RUN→REPORT transition.
- Reset asserted in any state, including during REPORT: the strobe is dropped, and the next cycle shows RUN with all outputs 0.
- Reset wins over simultaneous trap or watchdog expiry.
- A trap and a watchdog expiry in the same cycle: the trap wins, because commits occurred that cycle.

## Configuration
- `TRAP_WATCHDOG_EN` defined:
  - Adds a no-commit counter. It resets to 0 on any cycle with at least one valid lane, otherwise increments.
  - When it reaches `WDOG_LIMIT` in RUN, the block takes the RUN→REPORT transition with `trapCode`=`32'hFFFF_FFFF` and `trapPC`= PC of the youngest counted lane of the most recent commit cycle (0 if none since reset).
  - On that transition `cycleCnt` still increments and `instrCnt` is unchanged.
- `TRAP_WATCHDOG_EN` undefined:
  - No watchdog logic.
  - The only exit from RUN is a trap instruction.
  - `WDOG_LIMIT` is unused.

## Test plan
- Basic trap: COMMIT_WIDTH=2. Reset low 3 cycles. Commit 2 lanes/cycle for 10 cycles. Cycle 11: lane0 = `0x6b` at PC `0x80000100`, `trap_a0`=0. Expect one strobe in cycle 12 with `cycleCnt`=11, `instrCnt`=21, `trapPC`=`0x80000100`, `trapCode`=0.
- Lane priority: lane0 ordinary, lane1 trap (PC `0x80000204`, `trap_a0`=1) in cycle 1. Expect `instrCnt`=2, `trapPC`=`0x80000204`, `trapCode`=1. Then repeat with both lanes trapping: expect the lane0 PC and `instrCnt`=1.
- Post-trap inertness: after the strobe, drive further trap instructions for 20 cycles. Expect `isNoopTrap` to stay 0 and all outputs unchanged.
- Reset during REPORT: pull `reset` low in the strobe cycle. Expect all outputs 0 next cycle. A new trap after release reports counts from 0.
- Counter wrap: force `instrCnt` near `32'hFFFF_FFFF` via long run or hierarchical preload, then commit 2. Expect wrap to 1.
- Watchdog (`TRAP_WATCHDOG_EN`, `WDOG_LIMIT`=8): one commit at PC `0x80000010`, then idle. Expect a strobe 9 cycles after the last commit with `trapCode`=`0xFFFFFFFF` and `trapPC`=`0x80000010`. Without the macro: no strobe after 10000 idle cycles.
